// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags, captures CDB results,
// retires the head into the register file and flushes on mispredict.
module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int IX_W   = 3,
    parameter int DATA_W = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       alloc_valid_in,
    input  logic [4:0]                 alloc_rd_in,
    input  logic                       alloc_branch_in,
    output logic                       alloc_ready_out,
    output logic [IX_W-1:0]            alloc_ix_out,
    input  logic                       cdb_valid_in,
    input  logic [IX_W-1:0]            cdb_ix_in,
    input  logic [DATA_W-1:0]          cdb_data_in,
    input  logic                       cdb_mispredict_in,
    input  logic [IX_W-1:0]            lookup_ix1_in,
    input  logic [IX_W-1:0]            lookup_ix2_in,
    output logic                       lookup_ready1_out,
    output logic                       lookup_ready2_out,
    output logic [DATA_W-1:0]          lookup_data1_out,
    output logic [DATA_W-1:0]          lookup_data2_out,
    output logic                       commit_we_out,
    output logic [4:0]                 commit_wa_out,
    output logic [DATA_W-1:0]          commit_wd_out,
    output logic [IX_W-1:0]            commit_ix_out,
    output logic                       flush_out,
    output logic [DEPTH-1:0][4:0]      flush_addrs_out
);

    localparam logic [IX_W:0]   FULL = (IX_W+1)'(DEPTH);
    localparam logic [IX_W-1:0] ONE  = IX_W'(1);

    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0]              done_q, done_d;
    logic [DEPTH-1:0]              br_q, br_d;
    logic [DEPTH-1:0]              mp_q, mp_d;
    logic [DEPTH-1:0][4:0]         rd_q, rd_d;
    logic [DEPTH-1:0][DATA_W-1:0]  val_q, val_d;
    logic [IX_W-1:0]               head_q, head_d;
    logic [IX_W-1:0]               tail_q, tail_d;
    logic [IX_W:0]                 count_q, count_d;

    logic                          we_q, we_d;
    logic [4:0]                    wa_q, wa_d;
    logic [DATA_W-1:0]             wd_q, wd_d;
    logic [IX_W-1:0]               cix_q, cix_d;
    logic                          flush_q, flush_d;
    logic [DEPTH-1:0][4:0]         faddr_q, faddr_d;

    logic head_rdy;
    logic flush_pending;
    logic alloc_fire;

    assign head_rdy        = valid_q[head_q] && done_q[head_q];
    assign flush_pending   = head_rdy && mp_q[head_q];
    assign alloc_ready_out = (count_q < FULL) && !flush_pending;
    assign alloc_ix_out    = tail_q;
    assign alloc_fire      = alloc_valid_in && alloc_ready_out;

    assign commit_we_out   = we_q;
    assign commit_wa_out   = wa_q;
    assign commit_wd_out   = wd_q;
    assign commit_ix_out   = cix_q;
    assign flush_out       = flush_q;
    assign flush_addrs_out = faddr_q;

    // Operand lookup 1: CDB bypass first, then completed entry value
    always_comb begin
        lookup_ready1_out = 1'b0;
        lookup_data1_out  = '0;
        if (cdb_valid_in && (cdb_ix_in == lookup_ix1_in)) begin
            lookup_ready1_out = 1'b1;
            lookup_data1_out  = cdb_data_in;
        end else if (valid_q[lookup_ix1_in] && done_q[lookup_ix1_in]) begin
            lookup_ready1_out = 1'b1;
            lookup_data1_out  = val_q[lookup_ix1_in];
        end
    end

    // Operand lookup 2: same priority as lookup 1
    always_comb begin
        lookup_ready2_out = 1'b0;
        lookup_data2_out  = '0;
        if (cdb_valid_in && (cdb_ix_in == lookup_ix2_in)) begin
            lookup_ready2_out = 1'b1;
            lookup_data2_out  = cdb_data_in;
        end else if (valid_q[lookup_ix2_in] && done_q[lookup_ix2_in]) begin
            lookup_ready2_out = 1'b1;
            lookup_data2_out  = val_q[lookup_ix2_in];
        end
    end

    // Next state: CDB capture, allocation at tail, retire or flush at head
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        br_d    = br_q;
        mp_d    = mp_q;
        rd_d    = rd_q;
        val_d   = val_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        we_d    = 1'b0;
        wa_d    = '0;
        wd_d    = '0;
        cix_d   = '0;
        flush_d = 1'b0;
        faddr_d = '0;

        // Results arriving during a flush target entries being discarded
        if (cdb_valid_in && valid_q[cdb_ix_in] && !flush_pending) begin
            done_d[cdb_ix_in] = 1'b1;
            val_d[cdb_ix_in]  = cdb_data_in;
            mp_d[cdb_ix_in]   = cdb_mispredict_in && br_q[cdb_ix_in];
        end

        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            mp_d[tail_q]    = 1'b0;
            br_d[tail_q]    = alloc_branch_in;
            rd_d[tail_q]    = alloc_rd_in;
            tail_d          = tail_q + ONE;
        end

        if (head_rdy) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + ONE;
            cix_d           = head_q;
            if (flush_pending) begin
                flush_d = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && (IX_W'(i) != head_q)) begin
                        faddr_d[i] = rd_q[i];
                    end
                end
                valid_d = '0;
                tail_d  = head_q + ONE;
            end else if (rd_q[head_q] != 5'd0) begin
                we_d = 1'b1;
                wa_d = rd_q[head_q];
                wd_d = val_q[head_q];
            end
        end

        if (flush_pending) begin
            count_d = '0;
        end else if (alloc_fire && !head_rdy) begin
            count_d = count_q + 1'b1;
        end else if (!alloc_fire && head_rdy) begin
            count_d = count_q - 1'b1;
        end
    end

    // State and registered outputs, cleared immediately on reset
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
            done_q  <= '0;
            br_q    <= '0;
            mp_q    <= '0;
            rd_q    <= '0;
            val_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            cix_q   <= '0;
            flush_q <= 1'b0;
            faddr_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            br_q    <= br_d;
            mp_q    <= mp_d;
            rd_q    <= rd_d;
            val_q   <= val_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            cix_q   <= cix_d;
            flush_q <= flush_d;
            faddr_q <= faddr_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: vector table for dispatch/lookup,
// commit scoreboard, hand sequences for full, flush, reset.
`timescale 1ns/1ps
module tb_reorder_buffer;

    logic             clk;
    logic             rst_n;
    logic             alloc_valid;
    logic [4:0]       alloc_rd;
    logic             alloc_branch;
    logic             alloc_ready;
    logic [2:0]       alloc_ix;
    logic             cdb_valid;
    logic [2:0]       cdb_ix;
    logic [31:0]      cdb_data;
    logic             cdb_mp;
    logic [2:0]       lk1, lk2;
    logic             lr1, lr2;
    logic [31:0]      ld1, ld2;
    logic             c_we;
    logic [4:0]       c_wa;
    logic [31:0]      c_wd;
    logic [2:0]       c_ix;
    logic             fl;
    logic [7:0][4:0]  fa;

    reorder_buffer dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .alloc_valid_in    (alloc_valid),
        .alloc_rd_in       (alloc_rd),
        .alloc_branch_in   (alloc_branch),
        .alloc_ready_out   (alloc_ready),
        .alloc_ix_out      (alloc_ix),
        .cdb_valid_in      (cdb_valid),
        .cdb_ix_in         (cdb_ix),
        .cdb_data_in       (cdb_data),
        .cdb_mispredict_in (cdb_mp),
        .lookup_ix1_in     (lk1),
        .lookup_ix2_in     (lk2),
        .lookup_ready1_out (lr1),
        .lookup_ready2_out (lr2),
        .lookup_data1_out  (ld1),
        .lookup_data2_out  (ld2),
        .commit_we_out     (c_we),
        .commit_wa_out     (c_wa),
        .commit_wd_out     (c_wd),
        .commit_ix_out     (c_ix),
        .flush_out         (fl),
        .flush_addrs_out   (fa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ix;
        logic [4:0] rd;
    } exp_t;

    typedef struct {
        logic        av;
        logic [4:0]  rd;
        logic        cv;
        logic [2:0]  cix;
        logic [31:0] cd;
        logic [2:0]  l1;
        logic [2:0]  l2;
        logic        er1;
        logic [31:0] ed1;
        logic        er2;
        logic [31:0] ed2;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] exp_val[8];
    logic [2:0]  m_tail;
    int          n_checks;
    int          n_pass;
    vec_t        tbl[8];
    logic [7:0][4:0] fa_exp;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, want);
    endtask

    // One cycle of stimulus; comb outputs checked 3ns after the edge
    task automatic cyc(input logic av, input logic [4:0] rd,
                       input logic br, input logic acc,
                       input logic cv, input logic [2:0] cix,
                       input logic [31:0] cd, input logic cmp,
                       input logic [2:0] l1, input logic [2:0] l2);
        @(posedge clk);
        #1;
        alloc_valid  = av;
        alloc_rd     = rd;
        alloc_branch = br;
        cdb_valid    = cv;
        cdb_ix       = cix;
        cdb_data     = cd;
        cdb_mp       = cmp;
        lk1          = l1;
        lk2          = l2;
        if (cv) exp_val[cix] = cd;
        #2;
        if (av) begin
            chk("alloc_ready", 64'(alloc_ready), 64'(acc));
            chk("alloc_ix", 64'(alloc_ix), 64'(m_tail));
            if (acc) begin
                if (rd != 5'd0) sb.push_back('{ix: m_tail, rd: rd});
                m_tail = m_tail + 3'd1;
            end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_sb(input int n, input int budget);
        for (int i = 0; i < budget && sb.size() > n; i++) idle();
        chk("sb_level", 64'(sb.size()), 64'(n));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        alloc_valid = 0;
        cdb_valid   = 0;
        cdb_mp      = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 64'(c_we), 64'(0));
        chk("rst_flush", 64'(fl), 64'(0));
        chk("rst_faddr", 64'(fa), 64'(0));
        chk("rst_ready", 64'(alloc_ready), 64'(1));
        chk("rst_ix", 64'(alloc_ix), 64'(0));
        rst_n = 1'b1;
        sb.delete();
        m_tail = 3'd0;
    endtask

    // Commit monitor: every write pulse must match the oldest expected
    always @(negedge clk) begin
        if (rst_n && c_we) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_commit: got wa=%0d wd=%0h want none",
                         c_wa, c_wd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("commit", {24'd0, c_ix, c_wa, c_wd},
                    {24'd0, e.ix, e.rd, exp_val[e.ix]});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        m_tail       = 0;
        rst_n        = 0;
        alloc_valid  = 0;
        alloc_rd     = 0;
        alloc_branch = 0;
        cdb_valid    = 0;
        cdb_ix       = 0;
        cdb_data     = 0;
        cdb_mp       = 0;
        lk1          = 0;
        lk2          = 0;
        for (int i = 0; i < 8; i++) exp_val[i] = 0;

        tbl[0] = '{1, 5, 0, 0, 0,     0, 0, 0, 0,     0, 0};
        tbl[1] = '{1, 6, 0, 0, 0,     0, 1, 0, 0,     0, 0};
        tbl[2] = '{1, 7, 0, 0, 0,     1, 0, 0, 0,     0, 0};
        tbl[3] = '{0, 0, 1, 1, 'hB,   1, 0, 1, 'hB,   0, 0};
        tbl[4] = '{0, 0, 1, 0, 'hA,   1, 0, 1, 'hB,   1, 'hA};
        tbl[5] = '{0, 0, 0, 0, 0,     2, 0, 0, 0,     1, 'hA};
        tbl[6] = '{0, 0, 0, 0, 0,     1, 0, 1, 'hB,   0, 0};
        tbl[7] = '{0, 0, 1, 2, 'hC,   1, 2, 0, 0,     1, 'hC};

        // In-order commit with out-of-order completion
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].av, tbl[i].rd, 0, tbl[i].av, tbl[i].cv,
                tbl[i].cix, tbl[i].cd, 0, tbl[i].l1, tbl[i].l2);
            chk("lk1_rdy", 64'(lr1), 64'(tbl[i].er1));
            chk("lk1_data", 64'(ld1), 64'(tbl[i].ed1));
            chk("lk2_rdy", 64'(lr2), 64'(tbl[i].er2));
            chk("lk2_data", 64'(ld2), 64'(tbl[i].ed2));
            if (i == 4) chk("no_early_commit", 64'(sb.size()), 64'(3));
        end
        wait_sb(0, 20);

        // Full buffer, same-cycle commit does not reopen it
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 5'(i + 1), 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 'h100, 0, 0, 0);
        cyc(1, 21, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 20, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++)
            cyc(0, 0, 0, 0, 1, 3'(i), 32'h200 + 32'(i), 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 'h300, 0, 0, 0);
        wait_sb(0, 30);

        // Mispredicted branch at head flushes younger entries
        do_reset();
        cyc(1, 1,  0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 2,  0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0,  1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 9,  0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 12, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 'h10, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 'h11, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4, 'h1234, 0, 4, 0);
        chk("bypass_rdy", 64'(lr1), 64'(1));
        chk("bypass_data", 64'(ld1), 64'h1234);
        wait_sb(2, 20);
        cyc(0, 0, 0, 0, 1, 2, 'hDEAD, 1, 0, 0);
        cyc(1, 15, 0, 0, 1, 3, 'h99, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
        fa_exp    = '0;
        fa_exp[3] = 5'd9;
        fa_exp[4] = 5'd12;
        chk("flush_pulse", 64'(fl), 64'(1));
        chk("flush_addrs", 64'(fa), 64'(fa_exp));
        chk("br_no_we", 64'(c_we), 64'(0));
        chk("br_ix", 64'(c_ix), 64'(2));
        chk("post_flush_ready", 64'(alloc_ready), 64'(1));
        chk("post_flush_ix", 64'(alloc_ix), 64'(3));
        chk("flushed_lk1", 64'({lr1, ld1}), 64'(0));
        chk("flushed_lk2", 64'({lr2, ld2}), 64'(0));
        sb.delete();
        m_tail = 3'd3;
        idle();
        chk("flush_once", 64'(fl), 64'(0));
        chk("faddr_clear", 64'(fa), 64'(0));
        cyc(1, 14, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 'h44, 0, 0, 0);
        wait_sb(0, 20);

        // Silent retire of rd=0 followed by a real write
        do_reset();
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 'h77, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 'h33, 0, 0, 0);
        idle();
        chk("silent_we", 64'(c_we), 64'(0));
        chk("silent_ix", 64'(c_ix), 64'(0));
        chk("silent_pending", 64'(sb.size()), 64'(1));
        wait_sb(0, 10);

        // Reset dropped while a commit pulse is live
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 5'(i + 1), 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 'h5A, 0, 0, 0);
        idle();
        idle();
        chk("pre_rst_we", 64'({c_we, c_wa}), 64'({1'b1, 5'd1}));
        rst_n = 1'b0;
        #1;
        chk("async_we", 64'(c_we), 64'(0));
        chk("async_wa", 64'(c_wa), 64'(0));
        chk("async_wd", 64'(c_wd), 64'(0));
        chk("async_flush", 64'({fl, fa}), 64'(0));
        chk("async_ix", 64'(alloc_ix), 64'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_tail = 3'd0;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("post_rst_ix", 64'(alloc_ix), 64'(0));
        chk("post_rst_ready", 64'(alloc_ready), 64'(1));
        chk("post_rst_lk", 64'({lr1, lr2}), 64'(0));
        chk("post_rst_we", 64'(c_we), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
